fft_bitrev_swap: RTL and testbench

Sequencer that performs in-place bit-reversal reordering of a 64-point FFT sample buffer. It sits directly upstream of `rom_rev35`: it drives that ROM's `en`/`addr`, consumes its 9-bit `dout` (the 35 pair-representative indices), and for each entry swaps sample `i` with sample `bitrev6(i)` in an external 1R/1W sample RAM. It runs once per `start` pulse, after the last FFT stage has written its results and before the buffer is unloaded.

---
 rtl/fft_bitrev_swap_if.sv | 33 +++
 rtl/fft_bitrev_swap.sv | 154 +++++++++++++++
 tb/tb_fft_bitrev_swap.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_bitrev_swap_if.sv
// Bus bundle tying the bit-reversal sequencer to its controller, the
// pair-representative ROM and the 1R/1W sample RAM.
interface fft_bitrev_swap_if #(
  parameter int AW = 6,
  parameter int DW = 32
);
  logic          start;
  logic          busy;
  logic          done;
  logic          rom_en;
  logic [5:0]    rom_addr;
  logic [8:0]    rom_dout;
  logic          mem_rd_en;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  // Sequencer side
  modport master (
    input  start, rom_dout, mem_rdata,
    output busy, done, rom_en, rom_addr,
           mem_rd_en, mem_raddr, mem_we, mem_waddr, mem_wdata
  );

  // Environment side (controller, ROM, sample RAM)
  modport slave (
    output start, rom_dout, mem_rdata,
    input  busy, done, rom_en, rom_addr,
           mem_rd_en, mem_raddr, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/fft_bitrev_swap.sv
// In-place bit-reversal reorder of a 64-point sample buffer. Walks the
// pair-representative ROM and swaps x[i] with x[bitrev(i)] through a 1R/1W RAM.
module fft_bitrev_swap #(
  parameter int ROM_DEPTH = 35,
  parameter int AW        = 6,
  parameter int DW        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  fft_bitrev_swap_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_ROM_RD, S_ROM_WAIT, S_RD_I, S_RD_J, S_WR_I, S_WR_J, S_NEXT, S_DONE
  } state_t;

  localparam logic [5:0] LAST_K = 6'(ROM_DEPTH - 1);

  state_t        state_q, state_d;
  logic [5:0]    k_q, k_d;
  logic [AW-1:0] i_q, i_d, j_q, j_d;
  logic [DW-1:0] tmp_i_q, tmp_i_d;

  // Output hold registers: address/data outputs keep their last driven value
  logic [5:0]    rom_addr_q, rom_addr_d;
  logic [AW-1:0] mem_raddr_q, mem_raddr_d;
  logic [AW-1:0] mem_waddr_q, mem_waddr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic rom_en, mem_rd_en, mem_we, done;

  logic [AW-1:0] rom_i;
  logic          unused_rom_hi;

  // The table carries only the index in its low bits; upper bits are spare.
  assign rom_i         = bus.rom_dout[AW-1:0];
  assign unused_rom_hi = ^bus.rom_dout[8:AW];

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    r = '0;
    for (int b = 0; b < AW; b++) r[b] = v[AW-1-b];
    return r;
  endfunction

  // State, index/data and output-hold registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      tmp_i_q     <= '0;
      rom_addr_q  <= '0;
      mem_raddr_q <= '0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      i_q         <= i_d;
      j_q         <= j_d;
      tmp_i_q     <= tmp_i_d;
      rom_addr_q  <= rom_addr_d;
      mem_raddr_q <= mem_raddr_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state: palindromic indices skip the RAM phase entirely
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (bus.start) state_d = S_ROM_RD;
      S_ROM_RD:   state_d = S_ROM_WAIT;
      S_ROM_WAIT: state_d = (rom_i == bitrev(rom_i)) ? S_NEXT : S_RD_I;
      S_RD_I:     state_d = S_RD_J;
      S_RD_J:     state_d = S_WR_I;
      S_WR_I:     state_d = S_WR_J;
      S_WR_J:     state_d = S_NEXT;
      S_NEXT:     state_d = (k_q == LAST_K) ? S_DONE : S_ROM_RD;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Index walk and pair capture; x[i] is parked in tmp_i while x[j] streams through
  always_comb begin
    k_d     = k_q;
    i_d     = i_q;
    j_d     = j_q;
    tmp_i_d = tmp_i_q;
    case (state_q)
      S_IDLE:     if (bus.start) k_d = '0;
      S_ROM_WAIT: begin
        i_d = rom_i;
        j_d = bitrev(rom_i);
      end
      S_RD_J:     tmp_i_d = bus.mem_rdata;
      S_NEXT:     if (k_q != LAST_K) k_d = k_q + 6'd1;
      default:    ;
    endcase
  end

  // Outputs: strobes per state, addresses/data held outside their states
  always_comb begin
    rom_en      = 1'b0;
    mem_rd_en   = 1'b0;
    mem_we      = 1'b0;
    done        = 1'b0;
    rom_addr_d  = rom_addr_q;
    mem_raddr_d = mem_raddr_q;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_ROM_RD: begin
        rom_en     = 1'b1;
        rom_addr_d = k_q;
      end
      S_RD_I: begin
        mem_rd_en   = 1'b1;
        mem_raddr_d = i_q;
      end
      S_RD_J: begin
        mem_rd_en   = 1'b1;
        mem_raddr_d = j_q;
      end
      S_WR_I: begin
        mem_we      = 1'b1;
        mem_waddr_d = i_q;
        mem_wdata_d = bus.mem_rdata;
      end
      S_WR_J: begin
        mem_we      = 1'b1;
        mem_waddr_d = j_q;
        mem_wdata_d = tmp_i_q;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done;
  assign bus.rom_en    = rom_en;
  assign bus.rom_addr  = rom_addr_d;
  assign bus.mem_rd_en = mem_rd_en;
  assign bus.mem_raddr = mem_raddr_d;
  assign bus.mem_we    = mem_we;
  assign bus.mem_waddr = mem_waddr_d;
  assign bus.mem_wdata = mem_wdata_d;

endmodule

// File: tb/tb_fft_bitrev_swap.sv
// Bench for fft_bitrev_swap: ROM and sample-RAM models, a per-cycle schedule
// model derived from the pair table, and directed run scenarios.
module tb_fft_bitrev_swap;
  localparam int ROM_DEPTH = 35;
  localparam int AW = 6;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fft_bitrev_swap_if #(.AW(AW), .DW(DW)) bus ();

  fft_bitrev_swap #(.ROM_DEPTH(ROM_DEPTH), .AW(AW), .DW(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  int checks   = 0;
  int failures = 0;

  int          rom_tbl[$];
  logic [31:0] mem[64];
  logic [31:0] load_buf[64];
  logic [31:0] snap[64];
  logic        load_req;

  int cnt_rom, cnt_rd, cnt_we, cnt_pal;
  logic mon_prev_busy = 1'b0;

  typedef struct {
    bit        rom_en;
    bit [5:0]  rom_addr;
    bit        rd;
    bit [5:0]  raddr;
    bit        we;
    bit [5:0]  waddr;
    bit [31:0] wdata;
    bit        done;
  } step_t;

  step_t      exp_q[$];
  logic [5:0]  h_rom_addr, h_raddr, h_waddr;
  logic [31:0] h_wdata;

  function automatic int bitrev(input int v);
    int r = 0;
    for (int b = 0; b < 6; b++) r = r * 2 + ((v >> b) & 1);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [54:0] pack_out();
    return {bus.busy, bus.done, bus.rom_en, bus.rom_addr, bus.mem_rd_en, bus.mem_raddr,
            bus.mem_we, bus.mem_waddr, bus.mem_wdata};
  endfunction

  // ROM stand-in: registered read, index in low bits
  always @(posedge clk) begin
    if (bus.rom_en)
      bus.rom_dout <= (int'(bus.rom_addr) < rom_tbl.size()) ? {3'b000, 6'(rom_tbl[bus.rom_addr])} : 9'd0;
  end

  // Sample RAM: registered read, write on the same edge, bulk preload
  always @(posedge clk) begin
    if (load_req) begin
      for (int n = 0; n < 64; n++) mem[n] <= load_buf[n];
    end else begin
      if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_raddr];
      if (bus.mem_we) mem[bus.mem_waddr] <= bus.mem_wdata;
    end
  end

  // Expected cycle schedule of one run, from the table and the current buffer
  task automatic build_trace();
    step_t s;
    for (int k = 0; k < ROM_DEPTH; k++) begin
      int i, j;
      i = rom_tbl[k];
      j = bitrev(i);
      s = '{default: 0}; s.rom_en = 1; s.rom_addr = 6'(k); exp_q.push_back(s);
      s = '{default: 0}; exp_q.push_back(s);
      if (i != j) begin
        s = '{default: 0}; s.rd = 1; s.raddr = 6'(i); exp_q.push_back(s);
        s.raddr = 6'(j); exp_q.push_back(s);
        s = '{default: 0}; s.we = 1; s.waddr = 6'(i); s.wdata = mem[j]; exp_q.push_back(s);
        s.waddr = 6'(j); s.wdata = mem[i]; exp_q.push_back(s);
      end
      s = '{default: 0}; exp_q.push_back(s);
    end
    s = '{default: 0}; s.done = 1; exp_q.push_back(s);
  endtask

  // Per-cycle compare against the schedule model
  always @(negedge clk) begin
    step_t e;
    logic  busy_e;
    e = '{default: 0};
    busy_e = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      h_rom_addr = '0; h_raddr = '0; h_waddr = '0; h_wdata = '0;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      busy_e = 1'b1;
    end
    if (e.rom_en) h_rom_addr = e.rom_addr;
    if (e.rd) h_raddr = e.raddr;
    if (e.we) begin h_waddr = e.waddr; h_wdata = e.wdata; end
    check("cycle", pack_out(), {busy_e, e.done, e.rom_en, h_rom_addr, e.rd, h_raddr,
                                e.we, h_waddr, h_wdata});
    if (rst_n && !busy_e && bus.start) build_trace();
  end

  // Strobe counters per run, cleared when busy rises
  always @(negedge clk) begin
    if (bus.busy && !mon_prev_busy) begin
      cnt_rom = 0; cnt_rd = 0; cnt_we = 0; cnt_pal = 0;
    end
    if (bus.rom_en) cnt_rom++;
    if (bus.mem_rd_en) cnt_rd++;
    if (bus.mem_we) cnt_we++;
    if (bus.mem_we && (int'(bus.mem_waddr) inside {0, 12, 18, 30, 33, 45, 51, 63})) cnt_pal++;
    mon_prev_busy = bus.busy;
  end

  task automatic load_mem();
    @(posedge clk); #1 load_req = 1'b1;
    @(posedge clk); #1 load_req = 1'b0;
  endtask

  task automatic take_snap();
    for (int n = 0; n < 64; n++) snap[n] = mem[n];
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.done && cyc < 400);
  endtask

  task automatic run_once(output int cyc);
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_done(cyc);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_rom_en_pulses"}, cnt_rom, 35);
    check({tag, "_rd_pulses"}, cnt_rd, 56);
    check({tag, "_we_pulses"}, cnt_we, 56);
    check({tag, "_palindrome_writes"}, cnt_pal, 0);
  endtask

  task automatic check_perm(input string tag);
    for (int n = 0; n < 64; n++)
      check($sformatf("%s_buf[%0d]", tag, n), mem[n], snap[bitrev(n)]);
  endtask

  initial begin
    int cyc, pal;
    bit found;
    rst_n = 1'b0;
    bus.start = 1'b0;
    load_req = 1'b0;
    for (int n = 1; n < 64; n++) if (n <= bitrev(n)) rom_tbl.push_back(n);

    // Model pins
    pal = 0;
    foreach (rom_tbl[t]) if (rom_tbl[t] == bitrev(rom_tbl[t])) pal++;
    check("rom_table_size", rom_tbl.size(), 35);
    check("rom_table_palindromes", pal, 7);
    check("bitrev_1", bitrev(1), 32);
    check("bitrev_6", bitrev(6), 24);
    check("bitrev_3", bitrev(3), 48);

    for (int n = 0; n < 64; n++) load_buf[n] = 32'(n);
    load_mem();
    @(posedge clk); #1;
    check("reset_outputs", pack_out(), 0);
    rst_n = 1'b1;

    // Run 1 on identity buffer
    take_snap();
    run_once(cyc);
    check("run1_latency", cyc, 218);
    check_counts("run1");
    check("mem1", mem[1], 32);
    check("mem6", mem[6], 24);
    check("mem3", mem[3], 48);
    check("mem63", mem[63], 63);
    check("mem12", mem[12], 12);
    check("mem0", mem[0], 0);
    check_perm("run1");

    // Run 2 issued the cycle after done restores identity
    take_snap();
    run_once(cyc);
    check("run2_latency", cyc, 218);
    check_counts("run2");
    for (int n = 0; n < 64; n++) check($sformatf("identity[%0d]", n), mem[n], 32'(n));

    // Start held high: two back-to-back runs with one idle cycle between
    take_snap();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1;
    wait_done(cyc);
    check("hold_run1_latency", cyc, 218);
    wait_done(cyc);
    check("hold_gap", cyc, 219);
    #1 bus.start = 1'b0;
    check_counts("hold_run2");
    for (int n = 0; n < 64; n++) check($sformatf("hold_buf[%0d]", n), mem[n], snap[n]);

    // Random data preload
    for (int n = 0; n < 64; n++) load_buf[n] = $urandom;
    load_mem();
    take_snap();
    run_once(cyc);
    check("rand_latency", cyc, 218);
    check_perm("rand");

    // Reset during the first write phase at or after entry 10
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (cnt_rom >= 11 && bus.mem_we) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("reset_point_found", found, 1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", pack_out(), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    take_snap();
    run_once(cyc);
    check("after_reset_latency", cyc, 218);
    check_counts("after_reset");
    check_perm("after_reset");

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
